// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single data-memory port between two requesters: the core's
//   Execute-stage load/store path and an external loader/debug port. Each
//   granted access runs through IDLE -> ACCESS (MEM_LAT cycles) -> DONE, and
//   DONE returns a one-cycle ready pulse to whichever requester owned it.
//   Arbitration favours the core, except that ext wins once it has lost
//   STARVE_MAX consecutive arbitrations while waiting.
//
// Optional feature (macro DMEM_ARB_ADDR_GUARD_EN):
//   When defined, an ext write below GUARD_LIMIT is rejected at grant time.
//   The access still takes MEM_LAT cycles but never enables the memory, and
//   it completes with o_ext_ready=1 and o_ext_err=1. When the macro is not
//   defined there is no address check and o_ext_err stays 0.
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_core_req     core request, held until o_core_ready
//   i_core_we      core write enable (1=write, 0=read)
//   i_core_addr    core word address
//   i_core_wdata   core write data
//   o_core_rdata   last completed core read data
//   o_core_ready   one-cycle completion pulse to core
//   i_ext_req      ext request, held until o_ext_ready
//   i_ext_we       ext write enable
//   i_ext_addr     ext word address
//   i_ext_wdata    ext write data
//   o_ext_rdata    last completed ext read data
//   o_ext_ready    one-cycle completion pulse to ext
//   o_ext_err      qualifies o_ext_ready: access was rejected
//   o_mem_en       memory access enable
//   o_mem_we       memory write enable
//   o_mem_addr     memory word address
//   o_mem_wdata    memory write data
//   i_mem_rdata    memory read data
//   o_grant_ext    high while the current/last grant belongs to ext
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
`ifdef DMEM_ARB_ADDR_GUARD_EN
  ,
  parameter logic [ADDR_W-1:0] GUARD_LIMIT = ADDR_W'('h040)
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_core_ready,
  input  logic              i_ext_req,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wdata,
  output logic [DATA_W-1:0] o_ext_rdata,
  output logic              o_ext_ready,
  output logic              o_ext_err,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_grant_ext
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [LAT_W-1:0]   r_lat_cnt;
  logic [STV_W-1:0]   r_starve;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_owner_ext;
  logic               r_reject;
  logic               r_grant_ext;
  logic [DATA_W-1:0]  r_core_rdata;
  logic [DATA_W-1:0]  r_ext_rdata;

  logic               w_starve_full;
  logic               w_ext_wins;
  logic               w_grant_ext;
  logic               w_grant_core;
  logic               w_reject;

  // ext wins when it is alone, or when both request and it has already
  // lost STARVE_MAX times in a row; otherwise a requesting core wins.
  assign w_starve_full = (r_starve == STV_W'(STARVE_MAX));
  assign w_ext_wins    = i_ext_req && (!i_core_req || w_starve_full);

  assign o_core_rdata  = r_core_rdata;
  assign o_ext_rdata   = r_ext_rdata;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_grant_ext   = r_grant_ext;

  // Decides at grant time whether an ext write falls below the guard limit.
  always_comb begin
    w_reject = 1'b0;
`ifdef DMEM_ARB_ADDR_GUARD_EN
    w_reject = w_grant_ext && i_ext_we && (i_ext_addr < GUARD_LIMIT);
`endif
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, grant and output decode. A rejected access keeps its
  // ACCESS timing but never enables the memory.
  always_comb begin
    w_state_next = r_state;
    w_grant_ext  = 1'b0;
    w_grant_core = 1'b0;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_core_ready = 1'b0;
    o_ext_ready  = 1'b0;
    o_ext_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ext_wins) begin
          w_grant_ext  = 1'b1;
          w_state_next = S_ACCESS;
        end else if (i_core_req) begin
          w_grant_core = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_en = !r_reject;
        o_mem_we = r_we && !r_reject;
        if (r_lat_cnt == '0) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_core_ready = !r_owner_ext;
        o_ext_ready  = r_owner_ext;
`ifdef DMEM_ARB_ADDR_GUARD_EN
        o_ext_err    = r_owner_ext && r_reject;
`endif
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch the winner's request at grant, count down the access
  // latency, capture read data on the last ACCESS cycle, and track how many
  // times in a row ext has lost to the core.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_lat_cnt    <= '0;
      r_starve     <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner_ext  <= 1'b0;
      r_reject     <= 1'b0;
      r_grant_ext  <= 1'b0;
      r_core_rdata <= '0;
      r_ext_rdata  <= '0;
    end else begin
      if (w_grant_ext || w_grant_core) begin
        r_we        <= w_grant_ext ? i_ext_we    : i_core_we;
        r_addr      <= w_grant_ext ? i_ext_addr  : i_core_addr;
        r_wdata     <= w_grant_ext ? i_ext_wdata : i_core_wdata;
        r_owner_ext <= w_grant_ext;
        r_grant_ext <= w_grant_ext;
        r_reject    <= w_reject;
        r_lat_cnt   <= LAT_W'(MEM_LAT - 1);
      end

      if (w_grant_ext) begin
        r_starve <= '0;
      end else if (w_grant_core && i_ext_req && !w_starve_full) begin
        r_starve <= r_starve + 1'b1;
      end

      if (r_state == S_ACCESS) begin
        if (r_lat_cnt != '0) begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
        end else if (!r_we) begin
          if (r_owner_ext) begin
            r_ext_rdata <= i_mem_rdata;
          end else begin
            r_core_rdata <= i_mem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// random single-requester traffic, checked against a word-level memory model.
module tb_dmem_port_arbiter;

  localparam int         AddrW      = 10;
  localparam int         DataW      = 32;
  localparam int         MemLat     = 3;
  localparam int         StarveMax  = 4;
  localparam logic [9:0] GuardLimit = 10'h040;
`ifdef DMEM_ARB_ADDR_GUARD_EN
  localparam bit         GuardOn    = 1'b1;
`else
  localparam bit         GuardOn    = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             coreReq, coreWe, extReq, extWe;
  logic [AddrW-1:0] coreAddr, extAddr;
  logic [DataW-1:0] coreWdata, extWdata;
  logic [DataW-1:0] coreRdata, extRdata;
  logic             coreReady, extReady, extErr;
  logic             memEn, memWe, grantExt;
  logic [AddrW-1:0] memAddr;
  logic [DataW-1:0] memWdata, memRdata;

  int               vectors = 0;
  int               miscompares = 0;
  int               memEnCycles = 0;
  int               memWeCycles = 0;

  logic [31:0]      refMem [0:1023];
  logic [31:0]      expCoreRdata;
  logic [31:0]      expExtRdata;

  logic [31:0]      ramData [0:1023];
  bit               ramWritten [0:1023];

  dmem_port_arbiter #(
    .ADDR_W    (AddrW),
    .DATA_W    (DataW),
    .MEM_LAT   (MemLat),
    .STARVE_MAX(StarveMax)
  ) dut (
    .i_clk       (clock),
    .i_reset     (reset),
    .i_core_req  (coreReq),
    .i_core_we   (coreWe),
    .i_core_addr (coreAddr),
    .i_core_wdata(coreWdata),
    .o_core_rdata(coreRdata),
    .o_core_ready(coreReady),
    .i_ext_req   (extReq),
    .i_ext_we    (extWe),
    .i_ext_addr  (extAddr),
    .i_ext_wdata (extWdata),
    .o_ext_rdata (extRdata),
    .o_ext_ready (extReady),
    .o_ext_err   (extErr),
    .o_mem_en    (memEn),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .i_mem_rdata (memRdata),
    .o_grant_ext (grantExt)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Initial memory contents come from a fixed hash so the RAM and the model
  // agree without sharing storage.
  function automatic logic [31:0] seedWord(input int idx);
    return (32'h9E37_79B9 * 32'(idx + 1)) ^ 32'h5A5A_0000;
  endfunction

  // Behavioural RAM with asynchronous read, written only through the port.
  always @(posedge clock) begin
    if (memEn && memWe) begin
      ramData[memAddr]    <= memWdata;
      ramWritten[memAddr] <= 1'b1;
    end
  end
  assign memRdata = ramWritten[memAddr] ? ramData[memAddr] : seedWord(int'(memAddr));

  // Running totals of enabled memory cycles, sampled away from the edge.
  always @(negedge clock) begin
    if (memEn) memEnCycles++;
    if (memWe) memWeCycles++;
  end

  // Hard time limit so a stuck design cannot hang the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction from a single requester, issued from IDLE at a
  // falling edge; returns one falling edge after the ready pulse.
  task automatic applyStimulus(input bit isExt, input bit we, input logic [9:0] addr,
                               input logic [31:0] wdata, input bit dropEarly);
    int enStart;
    int weStart;
    int latency;
    bit expReject;
    expReject = GuardOn && isExt && we && (addr < GuardLimit);
    if (isExt) begin
      extWe = we; extAddr = addr; extWdata = wdata; extReq = 1'b1;
    end else begin
      coreWe = we; coreAddr = addr; coreWdata = wdata; coreReq = 1'b1;
    end
    enStart = memEnCycles;
    weStart = memWeCycles;
    latency = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (dropEarly) begin
        coreReq = 1'b0;
        extReq  = 1'b0;
      end
      if (memEn) begin
        checkOutput("mem_addr", 32'(memAddr), 32'(addr));
        checkOutput("mem_we", 32'(memWe), 32'(we));
        if (we) checkOutput("mem_wdata", memWdata, wdata);
      end else begin
        checkOutput("mem_we_off", 32'(memWe), 32'd0);
      end
      checkOutput("ready_overlap", 32'(coreReady & extReady), 32'd0);
      if (coreReady || extReady) begin
        latency = k;
        break;
      end
    end
    coreReq = 1'b0;
    extReq  = 1'b0;
    checkOutput("ready_latency", 32'(latency), 32'(MemLat + 1));
    checkOutput("core_ready", 32'(coreReady), 32'(!isExt));
    checkOutput("ext_ready", 32'(extReady), 32'(isExt));
    checkOutput("ext_err", 32'(extErr), 32'(expReject));
    checkOutput("grant_ext", 32'(grantExt), 32'(isExt));
    checkOutput("mem_en_cycles", 32'(memEnCycles - enStart), expReject ? 32'd0 : 32'(MemLat));
    checkOutput("mem_we_cycles", 32'(memWeCycles - weStart),
                (we && !expReject) ? 32'(MemLat) : 32'd0);
    if (we) begin
      if (!expReject) refMem[addr] = wdata;
    end else if (isExt) begin
      expExtRdata = refMem[addr];
    end else begin
      expCoreRdata = refMem[addr];
    end
    checkOutput("core_rdata", coreRdata, expCoreRdata);
    checkOutput("ext_rdata", extRdata, expExtRdata);
    @(negedge clock);
    checkOutput("ready_after_done", 32'(coreReady | extReady), 32'd0);
  endtask

  // Directed scenarios, then random traffic.
  initial begin
    int lost;
    int grants;
    int gap;
    bit expExtWin;
    bit rIsExt;
    bit rWe;
    logic [9:0]  rAddr;
    logic [31:0] rData;

    reset = 1'b0;
    coreReq = 1'b0; coreWe = 1'b0; coreAddr = '0; coreWdata = '0;
    extReq  = 1'b0; extWe  = 1'b0; extAddr  = '0; extWdata  = '0;
    for (int i = 0; i < 1024; i++) refMem[i] = seedWord(i);
    expCoreRdata = '0;
    expExtRdata  = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_mem_en", 32'(memEn), 32'd0);
    checkOutput("rst_mem_we", 32'(memWe), 32'd0);
    checkOutput("rst_core_ready", 32'(coreReady), 32'd0);
    checkOutput("rst_ext_ready", 32'(extReady), 32'd0);
    checkOutput("rst_ext_err", 32'(extErr), 32'd0);
    checkOutput("rst_grant_ext", 32'(grantExt), 32'd0);
    checkOutput("rst_core_rdata", coreRdata, 32'd0);
    checkOutput("rst_ext_rdata", extRdata, 32'd0);
    checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Core read
    applyStimulus(1'b0, 1'b0, 10'h005, 32'h0, 1'b0);

    // Both requesters held: core wins StarveMax times, then ext once
    coreWe = 1'b0; coreAddr = 10'h005;
    extWe  = 1'b0; extAddr  = 10'h100;
    coreReq = 1'b1;
    extReq  = 1'b1;
    lost = 0;
    grants = 0;
    gap = 0;
    for (int cyc = 1; cyc <= 200 && grants < 10; cyc++) begin
      @(negedge clock);
      gap++;
      checkOutput("arb_overlap", 32'(coreReady & extReady), 32'd0);
      if (coreReady || extReady) begin
        expExtWin = (lost == StarveMax);
        lost = expExtWin ? 0 : lost + 1;
        checkOutput("arb_ext_ready", 32'(extReady), 32'(expExtWin));
        checkOutput("arb_core_ready", 32'(coreReady), 32'(!expExtWin));
        checkOutput("arb_grant_ext", 32'(grantExt), 32'(expExtWin));
        checkOutput("arb_gap", 32'(gap), (grants == 0) ? 32'(MemLat + 1) : 32'(MemLat + 2));
        if (expExtWin) expExtRdata = refMem[10'h100];
        else           expCoreRdata = refMem[10'h005];
        checkOutput("arb_core_rdata", coreRdata, expCoreRdata);
        checkOutput("arb_ext_rdata", extRdata, expExtRdata);
        grants++;
        gap = 0;
      end
    end
    coreReq = 1'b0;
    extReq  = 1'b0;
    checkOutput("arb_grant_count", 32'(grants), 32'd10);
    @(negedge clock);

    // Ext write and read-back
    applyStimulus(1'b1, 1'b1, 10'h100, 32'h1234_5678, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h100, 32'h0, 1'b0);

    // Core drops its request mid-write; the write still completes
    applyStimulus(1'b0, 1'b1, 10'h010, 32'hCAFE_F00D, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      checkOutput("drop_no_grant", 32'(memEn), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 10'h010, 32'h0, 1'b0);

    // Guard boundary: below and at the limit
    applyStimulus(1'b1, 1'b1, 10'h020, 32'hBAD0_0020, 1'b0);
    applyStimulus(1'b1, 1'b0, 10'h020, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h040, 32'h600D_0040, 1'b0);
    applyStimulus(1'b0, 1'b0, 10'h040, 32'h0, 1'b0);

    // Reset asserted in the middle of an access
    coreWe = 1'b0; coreAddr = 10'h005; coreReq = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("pre_reset_mem_en", 32'(memEn), 32'd1);
    reset = 1'b0;
    coreReq = 1'b0;
    #1;
    checkOutput("midrst_mem_en", 32'(memEn), 32'd0);
    checkOutput("midrst_core_ready", 32'(coreReady), 32'd0);
    checkOutput("midrst_ext_ready", 32'(extReady), 32'd0);
    checkOutput("midrst_core_rdata", coreRdata, 32'd0);
    checkOutput("midrst_ext_rdata", extRdata, 32'd0);
    checkOutput("midrst_grant_ext", 32'(grantExt), 32'd0);
    expCoreRdata = '0;
    expExtRdata  = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput("midrst_no_ready", 32'(coreReady | extReady), 32'd0);
      checkOutput("midrst_mem_en_hold", 32'(memEn), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 10'h005, 32'h0, 1'b0);

    // Random single-requester traffic around the guard boundary
    for (int n = 0; n < 40; n++) begin
      rIsExt = 1'($urandom_range(0, 1));
      rWe    = 1'($urandom_range(0, 1));
      rAddr  = 10'($urandom_range(0, 15)) + ((1'($urandom_range(0, 1))) ? 10'h040 : 10'h030);
      rData  = $urandom;
      applyStimulus(rIsExt, rWe, rAddr, rData, 1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
